// File: rtl/encdec_pkg.sv
// encdec_pkg: shared encoder/decoder widths and decoder FSM state encoding
package encdec_pkg;
  localparam int CODE_W = 2;
  localparam int LINES = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;
endpackage

// File: rtl/decoder_hold_if.sv
// decoder_hold_if: code handshake in, held one-hot line and accept count out
interface decoder_hold_if #(
  parameter int CNT_W = 8
);
  import encdec_pkg::*;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              code_ready;
  logic [LINES-1:0]  dec_out;
  logic              dec_active;
  logic [CNT_W-1:0]  count_out;
  modport master (
    output code_in, code_valid,
    input  code_ready, dec_out, dec_active, count_out
  );
  modport slave (
    input  code_in, code_valid,
    output code_ready, dec_out, dec_active, count_out
  );
endinterface

// File: rtl/decoder_2to4.sv
// decoder_2to4: combinational code to one-hot line
module decoder_2to4
  import encdec_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LINES-1:0]  lines
);
  assign lines = LINES'(1) << code;
endmodule

// File: rtl/decoder_hold.sv
// decoder_hold: accepts a 2-bit code and holds its one-hot line, then forces a gap cycle
module decoder_hold
  import encdec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            reset,
  decoder_hold_if.slave  bus
);
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("decoder_hold: HOLD_CYCLES must be 1..255");
  end
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  state_t            state, state_n;
  logic [7:0]        hold_q, hold_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [LINES-1:0]  dec_w, dec_n;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  assign accept = bus.code_valid && bus.code_ready;
  assign bus.code_ready = state == ST_IDLE;
  assign bus.count_out = count_q;
  always_comb begin
    state_n = state == ST_IDLE ? (accept ? ST_HOLD : ST_IDLE) :
              state == ST_HOLD ? (hold_q == 8'd0 ? ST_GAP : ST_HOLD) : ST_IDLE;
    hold_n  = accept ? HOLD_LOAD :
              (state == ST_HOLD && hold_q != 8'd0) ? hold_q - 8'd1 : hold_q;
    code_n  = accept ? bus.code_in : code_q;
    dec_n   = state_n == ST_HOLD ? dec_w : '0;
  end
  decoder_2to4 u_dec (
    .code  (code_n),
    .lines (dec_w)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      hold_q         <= '0;
      code_q         <= '0;
      count_q        <= '0;
      bus.dec_out    <= '0;
      bus.dec_active <= 1'b0;
    end else begin
      state          <= state_n;
      hold_q         <= hold_n;
      code_q         <= code_n;
      count_q        <= count_q + CNT_W'(accept);
      bus.dec_out    <= dec_n;
      bus.dec_active <= |dec_n;
    end
  end
endmodule

// File: tb/tb_decoder_hold.sv
// tb_decoder_hold: directed checks of hold, gap, handshake, reset and counter wrap
module tb_decoder_hold;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  always #5 clk = ~clk;
  decoder_hold_if #(.CNT_W(8)) bus ();
  decoder_hold_if #(.CNT_W(2)) bus2 ();
  decoder_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  decoder_hold #(.HOLD_CYCLES(1), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int i = 0; i < 10 && bus.code_ready !== 1'b1; i++) step();
    total++;
    if (bus.code_ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_timeout ready=%b exp=1", bus.code_ready);
    end
  endtask
  task automatic test_reset();
    bus.code_valid = 1'b1;
    bus.code_in = 2'b11;
    bus2.code_valid = 1'b0;
    bus2.code_in = 2'b00;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.dec_out !== 4'b0000 || bus.dec_active !== 1'b0) begin
        bad++;
        $display("FAIL reset_dec got=%b/%b exp=0000/0", bus.dec_out, bus.dec_active);
      end
      total++;
      if (bus.count_out !== 8'd0) begin
        bad++;
        $display("FAIL reset_count got=%0d exp=0", bus.count_out);
      end
    end
    bus.code_valid = 1'b0;
    reset = 1'b0;
    step();
    total++;
    if (bus.code_ready !== 1'b1 || bus.dec_out !== 4'b0000 || bus.count_out !== 8'd0) begin
      bad++;
      $display("FAIL reset_release got rdy=%b dec=%b cnt=%0d exp rdy=1 dec=0000 cnt=0",
               bus.code_ready, bus.dec_out, bus.count_out);
    end
    exp_cnt = 0;
  endtask
  task automatic test_single();
    bus.code_in = 2'b10;
    bus.code_valid = 1'b1;
    step();
    bus.code_valid = 1'b0;
    exp_cnt++;
    total++;
    if (bus.count_out !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL single_count got=%0d exp=%0d", bus.count_out, exp_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.dec_out !== 4'b0100 || bus.dec_active !== 1'b1 || bus.code_ready !== 1'b0) begin
        bad++;
        $display("FAIL single_hold%0d got dec=%b act=%b rdy=%b exp dec=0100 act=1 rdy=0",
                 i, bus.dec_out, bus.dec_active, bus.code_ready);
      end
      step();
    end
    total++;
    if (bus.dec_out !== 4'b0000 || bus.dec_active !== 1'b0 || bus.code_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_gap got dec=%b act=%b rdy=%b exp dec=0000 act=0 rdy=0",
               bus.dec_out, bus.dec_active, bus.code_ready);
    end
    step();
    total++;
    if (bus.code_ready !== 1'b1 || bus.dec_out !== 4'b0000 || bus.count_out !== 8'(exp_cnt)) begin
      bad++;
      $display("FAIL single_idle got rdy=%b dec=%b cnt=%0d exp rdy=1 dec=0000 cnt=%0d",
               bus.code_ready, bus.dec_out, bus.count_out, exp_cnt);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] exp_dec;
    logic exp_rdy;
    int base;
    base = exp_cnt;
    bus.code_in = 2'b01;
    bus.code_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      exp_dec = (k % 6 < 4) ? 4'b0010 : 4'b0000;
      exp_rdy = (k % 6 == 5);
      total++;
      if (bus.dec_out !== exp_dec || bus.code_ready !== exp_rdy ||
          bus.count_out !== 8'(base + k / 6 + 1)) begin
        bad++;
        $display("FAIL b2b_k%0d got dec=%b rdy=%b cnt=%0d exp dec=%b rdy=%b cnt=%0d",
                 k, bus.dec_out, bus.code_ready, bus.count_out, exp_dec, exp_rdy, base + k / 6 + 1);
      end
    end
    bus.code_valid = 1'b0;
    exp_cnt = base + 4;
    drain();
  endtask
  task automatic test_sweep();
    logic [3:0] exp_dec;
    for (int c = 0; c < 4; c++) begin
      exp_dec = 4'(1 << c);
      bus.code_in = 2'(c);
      bus.code_valid = 1'b1;
      step();
      bus.code_valid = 1'b0;
      bus.code_in = 2'b11;
      exp_cnt++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (bus.dec_out !== exp_dec || bus.count_out !== 8'(exp_cnt)) begin
          bad++;
          $display("FAIL sweep_c%0d_%0d got dec=%b cnt=%0d exp dec=%b cnt=%0d",
                   c, i, bus.dec_out, bus.count_out, exp_dec, exp_cnt);
        end
        step();
      end
      drain();
    end
  endtask
  task automatic test_mid_reset();
    bus.code_in = 2'b11;
    bus.code_valid = 1'b1;
    step();
    bus.code_valid = 1'b0;
    total++;
    if (bus.dec_out !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_hold1 got=%b exp=1000", bus.dec_out);
    end
    step();
    total++;
    if (bus.dec_out !== 4'b1000) begin
      bad++;
      $display("FAIL midrst_hold2 got=%b exp=1000", bus.dec_out);
    end
    reset = 1'b1;
    step();
    total++;
    if (bus.dec_out !== 4'b0000 || bus.dec_active !== 1'b0 || bus.count_out !== 8'd0) begin
      bad++;
      $display("FAIL midrst_cut got dec=%b act=%b cnt=%0d exp dec=0000 act=0 cnt=0",
               bus.dec_out, bus.dec_active, bus.count_out);
    end
    reset = 1'b0;
    step();
    total++;
    if (bus.code_ready !== 1'b1 || bus.dec_out !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_release got rdy=%b dec=%b exp rdy=1 dec=0000", bus.code_ready, bus.dec_out);
    end
    exp_cnt = 0;
  endtask
  task automatic test_wrap();
    logic [1:0] exp_c;
    logic [3:0] exp_dec;
    for (int i = 1; i <= 5; i++) begin
      exp_c = 2'(i);
      exp_dec = 4'(1 << (i % 4));
      bus2.code_in = 2'(i);
      bus2.code_valid = 1'b1;
      step();
      bus2.code_valid = 1'b0;
      total++;
      if (bus2.count_out !== exp_c || bus2.dec_out !== exp_dec) begin
        bad++;
        $display("FAIL wrap_acc%0d got cnt=%0d dec=%b exp cnt=%0d dec=%b",
                 i, bus2.count_out, bus2.dec_out, exp_c, exp_dec);
      end
      step();
      total++;
      if (bus2.dec_out !== 4'b0000 || bus2.code_ready !== 1'b0) begin
        bad++;
        $display("FAIL wrap_gap%0d got dec=%b rdy=%b exp dec=0000 rdy=0", i, bus2.dec_out, bus2.code_ready);
      end
      step();
      total++;
      if (bus2.code_ready !== 1'b1) begin
        bad++;
        $display("FAIL wrap_idle%0d got rdy=%b exp=1", i, bus2.code_ready);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sweep();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
